// File: rtl/rob_active_list.sv
// In-order retirement buffer (active list): allocates from decode, marks completions,
// retires up to COMMIT_W entries per cycle. Optional perf counters via NAND_ROB_PERF_EN.
module rob_active_list #(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int AREG_W   = 2,
  parameter int PREG_W   = 4,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic                       alloc_has_dest,
  input  logic [AREG_W-1:0]          alloc_areg,
  input  logic [PREG_W-1:0]          alloc_preg,
  input  logic [PREG_W-1:0]          alloc_old_preg,
  input  logic                       alloc_is_halt,
  output logic [IDX_W-1:0]           alloc_idx,
  input  logic                       cmpl_valid,
  input  logic [IDX_W-1:0]           cmpl_idx,
  input  logic                       cmpl_mispredict,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W-1:0]        commit_has_dest,
  output logic [COMMIT_W*AREG_W-1:0] commit_areg,
  output logic [COMMIT_W*PREG_W-1:0] commit_preg,
  output logic [COMMIT_W*PREG_W-1:0] commit_old_preg,
  output logic                       flush,
  output logic                       empty,
  output logic                       halt
`ifdef NAND_ROB_PERF_EN
  ,
  output logic [31:0]                perf_full_cycles,
  output logic [31:0]                perf_retired
`endif
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic              has_dest;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic              is_halt;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  mp_q, mp_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flush_q, flush_d;
  logic              halt_q, halt_d;

  logic              alloc_fire;
  logic              cmpl_ok;
  logic [IDX_W-1:0]  cmpl_off;
  logic [IDX_W-1:0]  lane_idx;
  logic              chain;
  logic [CNT_W-1:0]  ret_cnt;
  logic              mp_ret;
  logic              halt_ret;

  assign alloc_ready = (count_q != DEPTH_C) && !halt_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail_q;
  assign empty       = (count_q == '0);
  assign flush       = flush_q;
  assign halt        = halt_q;

  // Completions only land inside the occupied window head..head+count-1.
  assign cmpl_off = cmpl_idx - head_q;
  assign cmpl_ok  = cmpl_valid && !flush_q && ({1'b0, cmpl_off} < count_q);

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    commit_valid    = '0;
    commit_has_dest = '0;
    commit_areg     = '0;
    commit_preg     = '0;
    commit_old_preg = '0;
    ret_cnt         = '0;
    mp_ret          = 1'b0;
    halt_ret        = 1'b0;
    lane_idx        = '0;
    chain           = !halt_q;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx = head_q + IDX_W'(k);
      if (chain && (CNT_W'(k) < count_q) && done_q[lane_idx]) begin
        commit_valid[k]                       = 1'b1;
        commit_has_dest[k]                    = mem_q[lane_idx].has_dest;
        commit_areg[k*AREG_W +: AREG_W]       = mem_q[lane_idx].areg;
        commit_preg[k*PREG_W +: PREG_W]       = mem_q[lane_idx].preg;
        commit_old_preg[k*PREG_W +: PREG_W]   = mem_q[lane_idx].old_preg;
        ret_cnt                               = ret_cnt + CNT_W'(1);
        if (mp_q[lane_idx])             mp_ret   = 1'b1;
        if (mem_q[lane_idx].is_halt)    halt_ret = 1'b1;
        // A retiring mispredict or halt closes the remaining lanes.
        chain = !mp_q[lane_idx] && !mem_q[lane_idx].is_halt;
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q + IDX_W'(ret_cnt);
    tail_d  = tail_q;
    count_d = count_q - ret_cnt;
    done_d  = done_q;
    mp_d    = mp_q;
    flush_d = 1'b0;
    halt_d  = halt_q | halt_ret;
    if (cmpl_ok) begin
      done_d[cmpl_idx] = 1'b1;
      mp_d[cmpl_idx]   = cmpl_mispredict;
    end
    if (mp_ret) begin
      // Wrong path squashed: everything younger than the branch disappears,
      // including any instruction trying to allocate this cycle.
      tail_d  = head_d;
      count_d = '0;
      done_d  = '0;
      mp_d    = '0;
      flush_d = 1'b1;
    end else if (alloc_fire) begin
      tail_d         = tail_q + IDX_W'(1);
      count_d        = count_d + CNT_W'(1);
      done_d[tail_q] = 1'b0;
      mp_d[tail_q]   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
      mp_q    <= '0;
      flush_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
      mp_q    <= mp_d;
      flush_q <= flush_d;
      halt_q  <= halt_d;
    end
  end

  // NOTE: the payload array has no reset; an entry is only read while occupied,
  // and occupancy is tracked by the reset pointers and done bits.
  always_ff @(posedge clk) begin
    if (alloc_fire && !mp_ret) begin
      mem_q[tail_q] <= '{has_dest: alloc_has_dest,
                         areg:     alloc_areg,
                         preg:     alloc_preg,
                         old_preg: alloc_old_preg,
                         is_halt:  alloc_is_halt};
    end
  end

`ifdef NAND_ROB_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_ret_q, perf_ret_d;
  logic [32:0] perf_ret_sum;

  always_comb begin
    perf_full_d  = perf_full_q;
    perf_ret_sum = {1'b0, perf_ret_q} + 33'(ret_cnt);
    perf_ret_d   = perf_ret_sum[32] ? '1 : perf_ret_sum[31:0];
    if ((count_q == DEPTH_C) && (perf_full_q != '1)) perf_full_d = perf_full_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      perf_full_q <= '0;
      perf_ret_q  <= '0;
    end else begin
      perf_full_q <= perf_full_d;
      perf_ret_q  <= perf_ret_d;
    end
  end

  assign perf_full_cycles = perf_full_q;
  assign perf_retired     = perf_ret_q;
`endif

endmodule
